// File: rtl/dm163_pkg.sv
// rtl/dm163_pkg.sv - DM163 receive-monitor constants, FSM states and pixel extraction helpers
package dm163_pkg;

    localparam int NUM_CHANNELS = 24;
    localparam int NUM_COLS     = 8;
    localparam int NUM_ROWS     = 8;
    localparam int GS_W         = 8;
    localparam int DC_W         = 6;
    localparam int BANK_GS_BITS = NUM_CHANNELS * GS_W;
    localparam int BANK_DC_BITS = NUM_CHANNELS * DC_W;

    localparam int OFS_B = 0;
    localparam int OFS_G = 1;
    localparam int OFS_R = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ROW,
        EMIT
    } rx_state_t;

    // Column c is driven by channels 3c (B), 3c+1 (G), 3c+2 (R); output order is {R, G, B}.
    function automatic logic [3*GS_W-1:0] gs_pixel(input logic [BANK_GS_BITS-1:0] bank,
                                                   input logic [2:0] col);
        int base;
        base = 3 * int'(col);
        return {bank[GS_W*(base+OFS_R) +: GS_W],
                bank[GS_W*(base+OFS_G) +: GS_W],
                bank[GS_W*(base+OFS_B) +: GS_W]};
    endfunction

    function automatic logic [3*DC_W-1:0] dc_pixel(input logic [BANK_DC_BITS-1:0] bank,
                                                   input logic [2:0] col);
        int base;
        base = 3 * int'(col);
        return {bank[DC_W*(base+OFS_R) +: DC_W],
                bank[DC_W*(base+OFS_G) +: DC_W],
                bank[DC_W*(base+OFS_B) +: DC_W]};
    endfunction

    function automatic logic is_onehot(input logic [NUM_ROWS-1:0] v);
        return (v != '0) && ((v & (v - NUM_ROWS'(1))) == '0);
    endfunction

    function automatic logic [2:0] onehot_index(input logic [NUM_ROWS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dm163_rx_sync.sv
// rtl/dm163_rx_sync.sv - multi-flop synchronizer with rising-edge detect on the synchronized level
module dm163_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   q_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
            q_d    <= 1'b0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
            q_d    <= stages[SYNC_STAGES-1];
        end
    end

    assign q    = stages[SYNC_STAGES-1];
    assign rise = stages[SYNC_STAGES-1] & ~q_d;

endmodule

// File: rtl/dm163_rx_monitor.sv
// rtl/dm163_rx_monitor.sv - DM163 link receiver: rebuilds latched rows as pixel writes (DM163_RX_DC_EN adds dc_value)
module dm163_rx_monitor
    import dm163_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_sda,
    input  logic        s_clk,
    input  logic        s_rst,
    input  logic        lat,
    input  logic        sb,
    input  logic [7:0]  channel,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [5:0]  pix_addr,
    output logic [23:0] pix_value,
    output logic        row_done,
    output logic        err_len,
    output logic        err_ovr
`ifdef DM163_RX_DC_EN
    ,
    output logic [17:0] dc_value
`endif
);

    logic sda_q, s_clk_q, s_rst_q, lat_q, sb_q;
    logic s_clk_rise, lat_rise;
    logic [NUM_ROWS-1:0] chan_q;
    logic [NUM_ROWS-1:0] unused_chan_rise;
    logic [3:0]          unused_rise;

    dm163_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(s_clk), .q(s_clk_q), .rise(s_clk_rise));
    dm163_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lat (
        .clk(clk), .rst(rst), .d(lat), .q(lat_q), .rise(lat_rise));
    dm163_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_srst (
        .clk(clk), .rst(rst), .d(s_rst), .q(s_rst_q), .rise(unused_rise[0]));
    dm163_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
        .clk(clk), .rst(rst), .d(s_sda), .q(sda_q), .rise(unused_rise[1]));
    dm163_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sb (
        .clk(clk), .rst(rst), .d(sb), .q(sb_q), .rise(unused_rise[2]));

    assign unused_rise[3] = s_clk_q ^ lat_q;

    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_chan_sync
        dm163_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_chan (
            .clk(clk), .rst(rst), .d(channel[i]), .q(chan_q[i]), .rise(unused_chan_rise[i]));
    end

    logic [BANK_GS_BITS-1:0] sr, sr_cur, held;
    logic [7:0]              bitcnt, cnt_cur;
    logic                    gs_ok, dc_ok, len_bad;
    rx_state_t               state;

    // Shift is folded in before the latch test so a same-cycle s_clk and lat rise sees the new bit.
    always_comb begin
        sr_cur  = sr;
        cnt_cur = bitcnt;
        if (!s_rst_q) begin
            sr_cur  = '0;
            cnt_cur = '0;
        end else if (s_clk_rise) begin
            sr_cur = {sr[BANK_GS_BITS-2:0], sda_q};
            if (bitcnt != 8'hff) cnt_cur = bitcnt + 8'd1;
        end
    end

    assign gs_ok   = lat_rise &&  sb_q && (cnt_cur == 8'(BANK_GS_BITS));
    assign dc_ok   = lat_rise && !sb_q && (cnt_cur == 8'(BANK_DC_BITS));
    assign len_bad = lat_rise && !gs_ok && !dc_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr        <= '0;
            bitcnt    <= '0;
            held      <= '0;
            state     <= IDLE;
            pix_valid <= 1'b0;
            pix_addr  <= '0;
            pix_value <= '0;
            row_done  <= 1'b0;
            err_len   <= 1'b0;
            err_ovr   <= 1'b0;
        end else begin
            sr       <= sr_cur;
            bitcnt   <= lat_rise ? 8'd0 : cnt_cur;
            err_len  <= len_bad;
            err_ovr  <= gs_ok && (state != IDLE);
            row_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (gs_ok) begin
                        held  <= sr_cur;
                        state <= WAIT_ROW;
                    end
                end
                WAIT_ROW: begin
                    // Blanking (no row) and multi-hot glitches between rows are skipped.
                    if (is_onehot(chan_q)) begin
                        pix_valid <= 1'b1;
                        pix_addr  <= {onehot_index(chan_q), 3'd0};
                        pix_value <= gs_pixel(held, 3'd0);
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (pix_valid && pix_ready) begin
                        if (pix_addr[2:0] == 3'(NUM_COLS - 1)) begin
                            pix_valid <= 1'b0;
                            pix_addr  <= '0;
                            pix_value <= '0;
                            row_done  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            pix_addr[2:0] <= pix_addr[2:0] + 3'd1;
                            pix_value     <= gs_pixel(held, pix_addr[2:0] + 3'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DM163_RX_DC_EN
    logic [BANK_DC_BITS-1:0] dc_bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc_bank <= '0;
        end else if (dc_ok) begin
            dc_bank <= sr_cur[BANK_DC_BITS-1:0];
        end
    end

    assign dc_value = dc_pixel(dc_bank, pix_addr[2:0]);
`else
    logic unused_dc;
    assign unused_dc = dc_ok;
`endif

endmodule

// File: tb/tb_dm163_rx_monitor.sv
// tb/tb_dm163_rx_monitor.sv - table-driven scoreboard bench for dm163_rx_monitor
module tb_dm163_rx_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_sda = 1'b0;
    logic        s_clk = 1'b0;
    logic        s_rst = 1'b1;
    logic        lat = 1'b0;
    logic        sb = 1'b0;
    logic [7:0]  channel = 8'h00;
    logic        pix_ready = 1'b1;
    logic        pix_valid;
    logic [5:0]  pix_addr;
    logic [23:0] pix_value;
    logic        row_done, err_len, err_ovr;
`ifdef DM163_RX_DC_EN
    logic [17:0] dc_value;
`endif

    always #5 clk = ~clk;

    dm163_rx_monitor #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .s_sda(s_sda), .s_clk(s_clk), .s_rst(s_rst),
        .lat(lat), .sb(sb), .channel(channel),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_addr(pix_addr),
        .pix_value(pix_value), .row_done(row_done), .err_len(err_len), .err_ovr(err_ovr)
`ifdef DM163_RX_DC_EN
        , .dc_value(dc_value)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    logic [29:0] exp_q[$];
    logic [29:0] mon_e;
    int accept_cnt = 0, row_done_cnt = 0, err_len_cnt = 0, err_ovr_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (pix_valid && pix_ready) begin
                accept_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got addr %0h value %0h, none required", pix_addr, pix_value);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pix_addr", 64'(pix_addr), 64'(mon_e[29:24]));
                    check("pix_value", 64'(pix_value), 64'(mon_e[23:0]));
                end
            end
            if (row_done) row_done_cnt++;
            if (err_len)  err_len_cnt++;
            if (err_ovr)  err_ovr_cnt++;
        end
    end

    // Backpressure: hold pix_ready low for stall_left cycles once column stall_col is shown.
    int          stall_left = 0;
    logic [2:0]  stall_col = 3'd0;
    logic        stall_snap = 1'b0;
    logic [29:0] snap;

    always @(posedge clk) begin
        #1;
        if (stall_left > 0 && pix_valid && pix_addr[2:0] == stall_col) begin
            if (stall_snap) begin
                check("stall_addr_hold", 64'(pix_addr), 64'(snap[29:24]));
                check("stall_value_hold", 64'(pix_value), 64'(snap[23:0]));
            end else begin
                snap = {pix_addr, pix_value};
            end
            stall_snap = 1'b1;
            pix_ready  = 1'b0;
            stall_left--;
        end else begin
            stall_snap = 1'b0;
            pix_ready  = 1'b1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [7:0] cur_ch[24];

    function automatic logic [255:0] build_gs();
        logic [255:0] d;
        d = '0;
        for (int k = 0; k < 24; k++) d[8*k +: 8] = cur_ch[k];
        return d;
    endfunction

    task automatic fill_ch(input int pattern);
        for (int k = 0; k < 24; k++) begin
            case (pattern)
                0:       cur_ch[k] = (k == 11) ? 8'hff : 8'h00;
                1:       cur_ch[k] = 8'h10 + 8'(k);
                default: cur_ch[k] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic shift_bits(input logic [255:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            s_sda = data[i];
            wait_clk(3);
            s_clk = 1'b1;
            wait_clk(3);
            s_clk = 1'b0;
        end
    endtask

    task automatic pulse_lat(input logic sbv);
        sb = sbv;
        wait_clk(3);
        lat = 1'b1;
        wait_clk(3);
        lat = 1'b0;
        wait_clk(4);
    endtask

    task automatic push_row(input logic [2:0] row);
        for (int c = 0; c < 8; c++) begin
            exp_q.push_back({row, 3'(c), cur_ch[3*c+2], cur_ch[3*c+1], cur_ch[3*c]});
        end
    endtask

    function automatic logic [2:0] row_of(input logic [7:0] ch);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (ch[i]) r = 3'(i);
        return r;
    endfunction

    task automatic wait_row_done(input int prev);
        int n;
        n = 0;
        while (row_done_cnt == prev && n < 3000) begin
            wait_clk(1);
            n++;
        end
        check("row_done_count", 64'(row_done_cnt), 64'(prev + 1));
    endtask

    task automatic wait_col(input logic [2:0] c);
        int n;
        n = 0;
        while (!(pix_valid && pix_addr[2:0] == c) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_col", 64'(pix_valid && pix_addr[2:0] == c), 64'(1));
    endtask

    typedef struct {
        int         nbits;
        logic       sbv;
        logic [7:0] chan;
        int         pattern;
        logic       emit;
        logic       bad_len;
    } vec_t;

    vec_t vecs[7];
    int   acc0, rd0, el0, eo0;

    initial begin
        vecs[0] = '{192, 1'b1, 8'h08, 0, 1'b1, 1'b0};
        vecs[1] = '{191, 1'b1, 8'h08, 1, 1'b0, 1'b1};
        vecs[2] = '{192, 1'b1, 8'h01, 1, 1'b1, 1'b0};
        vecs[3] = '{144, 1'b0, 8'h80, 2, 1'b0, 1'b0};
        vecs[4] = '{192, 1'b0, 8'h80, 2, 1'b0, 1'b1};
        vecs[5] = '{192, 1'b1, 8'h80, 2, 1'b1, 1'b0};
        vecs[6] = '{193, 1'b1, 8'h02, 1, 1'b0, 1'b1};

        wait_clk(4);
        check("reset_pix_valid", 64'(pix_valid), 64'(0));
        check("reset_pix_addr", 64'(pix_addr), 64'(0));
        check("reset_pix_value", 64'(pix_value), 64'(0));
        check("reset_pulses", 64'({row_done, err_len, err_ovr}), 64'(0));
        rst = 1'b0;
        wait_clk(4);

        for (int v = 0; v < 7; v++) begin
            fill_ch(vecs[v].pattern);
            channel = 8'h00;
            acc0 = accept_cnt; rd0 = row_done_cnt; el0 = err_len_cnt; eo0 = err_ovr_cnt;
            shift_bits(build_gs(), vecs[v].nbits);
            pulse_lat(vecs[v].sbv);
            check("vec_err_len", 64'(err_len_cnt - el0), 64'(vecs[v].bad_len));
            if (vecs[v].emit) push_row(row_of(vecs[v].chan));
            channel = vecs[v].chan;
            if (vecs[v].emit) begin
                wait_row_done(rd0);
                wait_clk(2);
                check("vec_accepts", 64'(accept_cnt - acc0), 64'(8));
            end else begin
                wait_clk(20);
                check("vec_no_accepts", 64'(accept_cnt - acc0), 64'(0));
                check("vec_no_row_done", 64'(row_done_cnt - rd0), 64'(0));
            end
            check("vec_queue_empty", 64'(exp_q.size()), 64'(0));
            check("vec_err_ovr", 64'(err_ovr_cnt - eo0), 64'(0));
            channel = 8'h00;
        end

        // Backpressure at column 2.
        fill_ch(2);
        acc0 = accept_cnt; rd0 = row_done_cnt;
        shift_bits(build_gs(), 192);
        pulse_lat(1'b1);
        push_row(3'd2);
        stall_col = 3'd2;
        stall_left = 5;
        channel = 8'h04;
        wait_row_done(rd0);
        wait_clk(2);
        check("stall_accepts", 64'(accept_cnt - acc0), 64'(8));
        check("stall_consumed", 64'(stall_left), 64'(0));
        channel = 8'h00;

        // Overrun: second valid latch while emitting column 4.
        fill_ch(2);
        acc0 = accept_cnt; rd0 = row_done_cnt; eo0 = err_ovr_cnt; el0 = err_len_cnt;
        shift_bits(build_gs(), 192);
        pulse_lat(1'b1);
        push_row(3'd5);
        fill_ch(1);
        shift_bits(build_gs(), 192);
        stall_col = 3'd4;
        stall_left = 60;
        channel = 8'h20;
        wait_col(3'd4);
        pulse_lat(1'b1);
        check("ovr_pulse", 64'(err_ovr_cnt - eo0), 64'(1));
        check("ovr_no_len_err", 64'(err_len_cnt - el0), 64'(0));
        wait_row_done(rd0);
        wait_clk(2);
        check("ovr_accepts", 64'(accept_cnt - acc0), 64'(8));
        check("ovr_queue_empty", 64'(exp_q.size()), 64'(0));
        channel = 8'h00;
        stall_left = 0;
        wait_clk(4);

        // Row select blanking and multi-hot are ignored.
        fill_ch(2);
        acc0 = accept_cnt; rd0 = row_done_cnt;
        shift_bits(build_gs(), 192);
        pulse_lat(1'b1);
        wait_clk(10);
        check("blank_no_valid", 64'(pix_valid), 64'(0));
        channel = 8'h30;
        wait_clk(10);
        check("multihot_no_valid", 64'(pix_valid), 64'(0));
        check("multihot_no_accepts", 64'(accept_cnt - acc0), 64'(0));
        push_row(3'd6);
        channel = 8'h40;
        wait_row_done(rd0);
        wait_clk(2);
        check("row6_accepts", 64'(accept_cnt - acc0), 64'(8));
        channel = 8'h00;

`ifdef DM163_RX_DC_EN
        begin
            logic [255:0] dcd;
            dcd = '0;
            dcd[6*5 +: 6] = 6'h3f;
            el0 = err_len_cnt;
            shift_bits(dcd, 144);
            pulse_lat(1'b0);
            check("dc_len_ok", 64'(err_len_cnt - el0), 64'(0));
        end
        fill_ch(2);
        rd0 = row_done_cnt;
        shift_bits(build_gs(), 192);
        pulse_lat(1'b1);
        push_row(3'd0);
        stall_col = 3'd1;
        stall_left = 3;
        channel = 8'h01;
        wait_col(3'd1);
        check("dc_value_col1", 64'(dc_value), 64'(18'h3f000));
        wait_row_done(rd0);
        channel = 8'h00;
        wait_clk(4);
`endif

        // Reset in the middle of a row aborts it without row_done.
        fill_ch(1);
        rd0 = row_done_cnt;
        shift_bits(build_gs(), 192);
        pulse_lat(1'b1);
        push_row(3'd0);
        stall_col = 3'd3;
        stall_left = 20;
        channel = 8'h01;
        wait_col(3'd3);
        rst = 1'b1;
        wait_clk(2);
        check("rst_abort_valid", 64'(pix_valid), 64'(0));
        exp_q.delete();
        stall_left = 0;
        rst = 1'b0;
        channel = 8'h00;
        wait_clk(20);
        check("rst_abort_no_row_done", 64'(row_done_cnt - rd0), 64'(0));
        check("rst_abort_idle", 64'(pix_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
